// File: rtl/mux_rr_reg.sv
// Registered N-channel mux with fixed-select or round-robin arbitration.
// Output side uses a valid/ready handshake; grants are one-hot, combinational.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   enable            allow a new capture this cycle
//   mode              0 = fixed select, 1 = round-robin
//   select            channel index used in fixed mode
//   req               per-channel request
//   data              packed channel data, channel i at [i*WIDTH +: WIDTH]
//   gnt               one-hot grant, channel captured at this edge
//   out_valid         output register holds a word
//   out_ready         downstream accepts the word
//   out_data          captured word, zero when out_valid = 0
//   out_chan          channel that supplied out_data

module mux_rr_reg #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          select,
    input  logic [CHANNELS-1:0]       req,
    input  logic [CHANNELS*WIDTH-1:0] data,
    output logic [CHANNELS-1:0]       gnt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan
);

    localparam logic [CHANNELS-1:0] ONE = {{(CHANNELS-1){1'b0}}, 1'b1};

    logic                valid_q, valid_d;
    logic [WIDTH-1:0]    data_q,  data_d;
    logic [SEL_W-1:0]    chan_q,  chan_d;
    logic [SEL_W-1:0]    ptr_q,   ptr_d;

    logic                load;
    logic [CHANNELS-1:0] sel_oh;
    logic [CHANNELS-1:0] ptr_mask;
    logic [CHANNELS-1:0] fix_gnt;
    logic [CHANNELS-1:0] req_hi;
    logic [CHANNELS-1:0] pick_hi;
    logic [CHANNELS-1:0] pick_all;
    logic [CHANNELS-1:0] rr_gnt;
    logic [CHANNELS-1:0] gnt_w;

    logic [WIDTH-1:0]    term  [CHANNELS];
    logic [SEL_W-1:0]    cterm [CHANNELS];
    logic [SEL_W-1:0]    nterm [CHANNELS];

    logic [WIDTH-1:0]    mux_data;
    logic [SEL_W-1:0]    mux_chan;
    logic [SEL_W-1:0]    mux_ptr;

    // A capture slot exists when the output register is empty or draining.
    assign load = enable && (!valid_q || out_ready);

    // Per-channel constant decodes. An out-of-range select matches no bit,
    // and ptr_mask marks channels at or above the rotation pointer.
    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_chan
            assign sel_oh[i]   = (select == SEL_W'(i));
            assign ptr_mask[i] = (SEL_W'(i) >= ptr_q);

            assign term[i]  = {WIDTH{gnt_w[i]}} & data[i*WIDTH +: WIDTH];
            assign cterm[i] = {SEL_W{gnt_w[i]}} & SEL_W'(i);

            if (i == CHANNELS - 1) begin : g_wrap
                assign nterm[i] = '0;
            end else begin : g_next
                assign nterm[i] = {SEL_W{gnt_w[i]}} & SEL_W'(i + 1);
            end
        end
    endgenerate

    assign fix_gnt = sel_oh & req;

    // Round-robin: lowest requester at or above ptr, else lowest overall.
    // x & (~x + 1) isolates the lowest set bit.
    assign req_hi   = req & ptr_mask;
    assign pick_hi  = req_hi & (~req_hi + ONE);
    assign pick_all = req & (~req + ONE);
    assign rr_gnt   = (|req_hi) ? pick_hi : pick_all;

    assign gnt_w = (rst_n && load) ? (mode ? rr_gnt : fix_gnt) : '0;
    assign gnt   = gnt_w;

    // AND-OR reduction across the one-hot grant.
    always_comb begin
        mux_data = '0;
        mux_chan = '0;
        mux_ptr  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            mux_data = mux_data | term[k];
            mux_chan = mux_chan | cterm[k];
            mux_ptr  = mux_ptr  | nterm[k];
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        chan_d  = chan_q;
        ptr_d   = ptr_q;
        if (|gnt_w) begin
            valid_d = 1'b1;
            data_d  = mux_data;
            chan_d  = mux_chan;
            ptr_d   = mux_ptr;
        end else if (!valid_q || out_ready) begin
            // Empty slot with nothing to capture, or a drain
            // while capture is disabled.
            valid_d = 1'b0;
            data_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_chan  = chan_q;

endmodule

// File: tb/tb_mux_rr_reg.sv
// Directed testbench for mux_rr_reg.
// Instance a: 4 channels; instance b: 3 channels for out-of-range select.

module tb_mux_rr_reg;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        enable, mode, out_ready;
    logic [1:0]  select;
    logic [3:0]  req;
    logic [15:0] data;
    logic [3:0]  gnt;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [1:0]  out_chan;

    logic        b_enable, b_mode, b_ready;
    logic [1:0]  b_select;
    logic [2:0]  b_req;
    logic [11:0] b_data;
    logic [2:0]  b_gnt;
    logic        b_valid;
    logic [3:0]  b_odata;
    logic [1:0]  b_chan;

    int checks = 0;
    int errors = 0;

    mux_rr_reg #(.WIDTH(4), .CHANNELS(4), .SEL_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .select(select), .req(req), .data(data), .gnt(gnt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_chan(out_chan)
    );

    mux_rr_reg #(.WIDTH(4), .CHANNELS(3), .SEL_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(b_enable), .mode(b_mode),
        .select(b_select), .req(b_req), .data(b_data), .gnt(b_gnt),
        .out_valid(b_valid), .out_ready(b_ready),
        .out_data(b_odata), .out_chan(b_chan)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        enable = 1'b1; mode = 1'b0; select = 2'd0; out_ready = 1'b1;
        req = 4'b1111; data = 16'hDCBA;
        b_enable = 1'b1; b_mode = 1'b0; b_select = 2'd0; b_ready = 1'b1;
        b_req = 3'b000; b_data = 12'h987;
        rst_n = 1'b0;
        step; step;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++; $display("FAIL reset_gnt got %b exp 0000", gnt);
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || out_chan !== 2'd0) begin
            errors++;
            $display("FAIL reset_out got v=%b d=%h c=%0d exp 0/0/0",
                     out_valid, out_data, out_chan);
        end
        checks++;
        if (b_valid !== 1'b0) begin
            errors++; $display("FAIL reset_b_valid got %b exp 0", b_valid);
        end
        req = 4'b0000;
        rst_n = 1'b1;
        step;
        checks++;
        if (out_valid !== 1'b0 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_reset got v=%b g=%b exp 0/0000",
                     out_valid, gnt);
        end
    endtask

    task automatic test_fixed;
        mode = 1'b0; select = 2'd2; req = 4'b1111; enable = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0100) begin
            errors++; $display("FAIL fixed_gnt got %b exp 0100", gnt);
        end
        step;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'hC || out_chan !== 2'd2) begin
            errors++;
            $display("FAIL fixed_out got v=%b d=%h c=%0d exp 1/C/2",
                     out_valid, out_data, out_chan);
        end
        enable = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++; $display("FAIL disabled_gnt got %b exp 0000", gnt);
        end
        step;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || out_chan !== 2'd2) begin
            errors++;
            $display("FAIL drain got v=%b d=%h c=%0d exp 0/0/2",
                     out_valid, out_data, out_chan);
        end
    endtask

    task automatic test_mode_switch;
        enable = 1'b1; mode = 1'b1; req = 4'b1111;
        #1;
        checks++;
        if (gnt !== 4'b1000) begin
            errors++; $display("FAIL switch_gnt3 got %b exp 1000", gnt);
        end
        step;
        checks++;
        if (out_chan !== 2'd3 || out_data !== 4'hD) begin
            errors++;
            $display("FAIL switch_out3 got d=%h c=%0d exp D/3",
                     out_data, out_chan);
        end
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++; $display("FAIL switch_gnt0 got %b exp 0001", gnt);
        end
        step;
        checks++;
        if (out_chan !== 2'd0 || out_data !== 4'hA || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL switch_out0 got v=%b d=%h c=%0d exp 1/A/0",
                     out_valid, out_data, out_chan);
        end
    endtask

    task automatic test_reset_midstream;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || out_chan !== 2'd0) begin
            errors++;
            $display("FAIL midreset_out got v=%b d=%h c=%0d exp 0/0/0",
                     out_valid, out_data, out_chan);
        end
        checks++;
        if (gnt !== 4'b0000) begin
            errors++; $display("FAIL midreset_gnt got %b exp 0000", gnt);
        end
        step;
        req = 4'b0000;
        rst_n = 1'b1;
        step;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_idle got %b exp 0", out_valid);
        end
    endtask

    task automatic test_rr;
        logic [1:0] exp_c [4];
        logic [3:0] exp_d [4];
        exp_c = '{2'd0, 2'd1, 2'd3, 2'd0};
        exp_d = '{4'hA, 4'hB, 4'hD, 4'hA};
        mode = 1'b1; enable = 1'b1; out_ready = 1'b1; req = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (gnt !== (4'b0001 << exp_c[k])) begin
                errors++;
                $display("FAIL rr_gnt[%0d] got %b exp ch%0d", k, gnt, exp_c[k]);
            end
            step;
            checks++;
            if (out_valid !== 1'b1 || out_chan !== exp_c[k] ||
                out_data !== exp_d[k]) begin
                errors++;
                $display("FAIL rr_out[%0d] got v=%b d=%h c=%0d exp 1/%h/%0d",
                         k, out_valid, out_data, out_chan, exp_d[k], exp_c[k]);
            end
        end
    endtask

    task automatic test_backpressure;
        req = 4'b0010;
        #1;
        checks++;
        if (gnt !== 4'b0010) begin
            errors++; $display("FAIL bp_setup_gnt got %b exp 0010", gnt);
        end
        step;
        checks++;
        if (out_chan !== 2'd1 || out_data !== 4'hB) begin
            errors++;
            $display("FAIL bp_setup_out got d=%h c=%0d exp B/1",
                     out_data, out_chan);
        end
        out_ready = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (gnt !== 4'b0000) begin
                errors++; $display("FAIL bp_gnt[%0d] got %b exp 0000", k, gnt);
            end
            step;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 4'hB || out_chan !== 2'd1) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%b d=%h c=%0d exp 1/B/1",
                         k, out_valid, out_data, out_chan);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0100) begin
            errors++; $display("FAIL bp_release_gnt got %b exp 0100", gnt);
        end
        step;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'hC || out_chan !== 2'd2) begin
            errors++;
            $display("FAIL bp_release_out got v=%b d=%h c=%0d exp 1/C/2",
                     out_valid, out_data, out_chan);
        end
    endtask

    task automatic test_no_candidate;
        req = 4'b0000; enable = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++; $display("FAIL nocand_gnt got %b exp 0000", gnt);
        end
        step;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || out_chan !== 2'd2) begin
            errors++;
            $display("FAIL nocand_out got v=%b d=%h c=%0d exp 0/0/2",
                     out_valid, out_data, out_chan);
        end
    endtask

    task automatic test_out_of_range;
        b_enable = 1'b1; b_ready = 1'b1; b_mode = 1'b0; b_select = 2'd3;
        b_req = 3'b111; b_data = 12'h987;
        #1;
        checks++;
        if (b_gnt !== 3'b000) begin
            errors++; $display("FAIL oor_gnt got %b exp 000", b_gnt);
        end
        step;
        checks++;
        if (b_valid !== 1'b0) begin
            errors++; $display("FAIL oor_valid got %b exp 0", b_valid);
        end
        b_mode = 1'b1;
        #1;
        checks++;
        if (b_gnt !== 3'b001) begin
            errors++; $display("FAIL oor_rr_gnt got %b exp 001", b_gnt);
        end
        step;
        checks++;
        if (b_valid !== 1'b1 || b_chan !== 2'd0 || b_odata !== 4'h7) begin
            errors++;
            $display("FAIL oor_rr_out got v=%b d=%h c=%0d exp 1/7/0",
                     b_valid, b_odata, b_chan);
        end
    endtask

    initial begin
        test_reset;
        test_fixed;
        test_mode_switch;
        test_reset_midstream;
        test_rr;
        test_backpressure;
        test_no_candidate;
        test_out_of_range;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
